// File: rtl/acumulador_somas_pkg.sv
// Shared arithmetic definitions for the sum-accumulator datapath stage:
// FSM state encoding, default operand/sum widths and the accumulator
// width helper used to size the block total without overflow.
package pkg_aritmetica;

   typedef enum logic [0:0] {
      ACUMULA = 1'b0,
      ENTREGA = 1'b1
   } estado_acum_t;

   localparam int LARG_SOMA     = 9;
   localparam int LARG_OPERANDO = 8;

   // Width needed to hold n_amostras sums of larg_in bits without wrapping.
   function automatic int larg_acumulador(input int larg_in, input int n_amostras);
      return larg_in + $clog2(n_amostras);
   endfunction

endpackage

// File: rtl/acumulador_somas_contador_amostras.sv
// Modulo-N sample counter for acumulador_somas. Counts accepted sums in the
// current block and flags the last sample so the top can close the block.
// A synchronous clear takes priority over the enable.
module contador_amostras #(
   parameter int N    = 4,
   parameter int LARG = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            en_i,
   input  logic            limpa_i,
   output logic [LARG-1:0] contagem_o,
   output logic            ultima_o
);

   localparam logic [LARG-1:0] ULTIMO = LARG'(N - 1);

   logic [LARG-1:0] cnt_q;
   logic [LARG-1:0] cnt_d;

   // Next count: clear wins, otherwise step and wrap after the last sample.
   always_comb begin
      cnt_d = cnt_q;
      if (limpa_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = (cnt_q == ULTIMO) ? '0 : cnt_q + LARG'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign contagem_o = cnt_q;
   assign ultima_o   = (cnt_q == ULTIMO);

endmodule

// File: rtl/acumulador_somas.sv
// Block accumulator for the ripple adder's sum stream. Adds N_AMOSTRAS
// accepted sums and presents the block total on a valid/ready output.
// Build option ACUMULADOR_MEDIA_EN: present the truncated block average
// (total >> log2(N_AMOSTRAS)) instead of the total; handshake is unchanged.
//
// state   | meaning
// ACUMULA | accepting sums, in_ready=1, out_valid=0
// ENTREGA | result held on out_data, in_ready=0, waiting for out_ready
module acumulador_somas
   import pkg_aritmetica::*;
#(
   parameter int WIDTH_IN   = LARG_SOMA,
   parameter int N_AMOSTRAS = 4,
   parameter int WIDTH_ACC  = larg_acumulador(WIDTH_IN, N_AMOSTRAS)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          limpa,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [WIDTH_IN-1:0]           in_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [WIDTH_ACC-1:0]          out_data,
   output logic [$clog2(N_AMOSTRAS)-1:0] contagem
);

   localparam int LARG_CONT = $clog2(N_AMOSTRAS);

   estado_acum_t         estado_q;
   estado_acum_t         estado_d;
   logic [WIDTH_ACC-1:0] acc_q;
   logic [WIDTH_ACC-1:0] acc_d;
   logic [WIDTH_ACC-1:0] out_data_q;
   logic [WIDTH_ACC-1:0] out_data_d;
   logic                 out_valid_q;
   logic                 out_valid_d;

   logic                 aceita;
   logic                 ultima;
   logic [WIDTH_ACC-1:0] soma_total;
   logic [WIDTH_ACC-1:0] resultado;

   assign in_ready   = (estado_q == ACUMULA);
   assign aceita     = in_valid & in_ready;
   assign soma_total = acc_q + WIDTH_ACC'(in_data);

`ifdef ACUMULADOR_MEDIA_EN
   // Power-of-two block size makes the average a plain right shift.
   assign resultado = soma_total >> LARG_CONT;
`else
   assign resultado = soma_total;
`endif

   // The counter only advances on handshakes that limpa does not discard.
   contador_amostras #(
      .N    (N_AMOSTRAS),
      .LARG (LARG_CONT)
   ) u_contador (
      .clk        (clk),
      .rst_n      (rst_n),
      .en_i       (aceita & ~limpa),
      .limpa_i    (limpa),
      .contagem_o (contagem),
      .ultima_o   (ultima)
   );

   // Next state, accumulator and result; limpa overrides everything.
   always_comb begin
      estado_d    = estado_q;
      acc_d       = acc_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      if (limpa) begin
         estado_d    = ACUMULA;
         acc_d       = '0;
         out_valid_d = 1'b0;
      end else begin
         case (estado_q)
            ACUMULA: begin
               if (aceita) begin
                  if (ultima) begin
                     out_data_d  = resultado;
                     out_valid_d = 1'b1;
                     acc_d       = '0;
                     estado_d    = ENTREGA;
                  end else begin
                     acc_d = soma_total;
                  end
               end
            end
            ENTREGA: begin
               if (out_ready) begin
                  out_valid_d = 1'b0;
                  estado_d    = ACUMULA;
               end
            end
            default: begin
               estado_d    = ACUMULA;
               acc_d       = '0;
               out_valid_d = 1'b0;
            end
         endcase
      end
   end

   // State, accumulator and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado_q    <= ACUMULA;
         acc_q       <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         estado_q    <= estado_d;
         acc_q       <= acc_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

endmodule

// File: tb/tb_acumulador_somas.sv
// Self-checking bench for acumulador_somas: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// block-level model of the accumulator.
module tb_acumulador_somas;

   localparam int N = 4;
`ifdef ACUMULADOR_MEDIA_EN
   localparam bit MEDIA = 1'b1;
`else
   localparam bit MEDIA = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        limpa;
   logic        in_valid;
   logic        in_ready;
   logic [8:0]  in_data;
   logic        out_valid;
   logic        out_ready;
   logic [10:0] out_data;
   logic [1:0]  contagem;

   int checks = 0;
   int errors = 0;

   acumulador_somas dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .limpa     (limpa),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .contagem  (contagem)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nome, input int atual, input int esperado);
      checks++;
      if (atual != esperado) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", nome, atual, esperado, $time);
      end
   endtask

   // Block-level model: number of sums taken, running total, pending result.
   int m_cont  = 0;
   int m_total = 0;
   int m_res   = 0;
   bit m_tem   = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cont  = 0;
         m_total = 0;
         m_tem   = 1'b0;
      end else if (limpa) begin
         m_cont  = 0;
         m_total = 0;
         m_tem   = 1'b0;
      end else if (m_tem) begin
         if (out_ready) m_tem = 1'b0;
      end else if (in_valid) begin
         m_total = m_total + int'(in_data);
         m_cont  = m_cont + 1;
         if (m_cont == N) begin
            m_res   = MEDIA ? m_total / N : m_total;
            m_tem   = 1'b1;
            m_cont  = 0;
            m_total = 0;
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("in_ready", int'(in_ready), int'(!m_tem));
         chk("out_valid", int'(out_valid), int'(m_tem));
         if (m_tem) chk("out_data", int'(out_data), m_res);
         chk("contagem", int'(contagem), m_cont);
      end
   end

   // Offer one sum and return just after the edge that accepts it.
   task automatic send(input int d);
      bit ok;
      ok = 1'b0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 9'(d);
      for (int i = 0; i < 50; i++) begin
         if (in_ready && !limpa) ok = 1'b1;
         @(posedge clk);
         if (ok) break;
         @(negedge clk);
      end
      if (!ok) chk("send_timeout", 0, 1);
   endtask

   task automatic drain();
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int pat [7] = '{1, 0, 0, 1, 1, 0, 1};
      int expc[7] = '{1, 1, 1, 2, 3, 3, 0};

      rst_n = 1'b0; limpa = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_out_valid", int'(out_valid), 0);
      chk("reset_out_data", int'(out_data), 0);
      chk("reset_contagem", int'(contagem), 0);
      rst_n = 1'b1;
      #1 chk("reset_in_ready", int'(in_ready), 1);

      // Reset mid-block drops the partial sum.
      send(10); send(20);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      chk("midreset_contagem", int'(contagem), 0);
      chk("midreset_out_valid", int'(out_valid), 0);
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      send(1); send(2); send(3); send(4);
      #1;
      chk("blk1_valid", int'(out_valid), 1);
      chk("blk1_data", int'(out_data), MEDIA ? 2 : 10);
      chk("model_blk1", m_res, MEDIA ? 2 : 10);
      drain();

      // Maximum values.
      out_ready = 1'b1;
      send(510); send(510); send(510); send(510);
      #1;
      chk("max_valid", int'(out_valid), 1);
      chk("max_data", int'(out_data), MEDIA ? 510 : 2040);
      chk("model_max", m_res, MEDIA ? 510 : 2040);
      drain();

      // Backpressure with a fifth sum waiting.
      out_ready = 1'b0;
      send(100); send(200); send(300); send(400);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 9'd5;
      for (int i = 0; i < 5; i++) begin
         chk("bp_in_ready", int'(in_ready), 0);
         chk("bp_out_valid", int'(out_valid), 1);
         chk("bp_data", int'(out_data), MEDIA ? 250 : 1000);
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1 chk("bp_fifth_held", int'(contagem), 0);
      @(negedge clk);
      out_ready = 1'b0;
      @(posedge clk);
      #1 chk("bp_fifth_taken", int'(contagem), 1);
      send(5); send(5); send(5);
      #1 chk("bp_blk2", int'(out_data), MEDIA ? 5 : 20);
      drain();

      // Input stalls.
      out_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         in_valid = pat[i][0];
         in_data  = 9'd7;
         @(posedge clk);
         #1 chk("stall_contagem", int'(contagem), expc[i]);
      end
      chk("stall_valid", int'(out_valid), 1);
      chk("stall_data", int'(out_data), MEDIA ? 7 : 28);
      drain();

      // limpa discards a simultaneous handshake and the partial block.
      send(50); send(60);
      @(negedge clk);
      limpa    = 1'b1;
      in_valid = 1'b1;
      in_data  = 9'd70;
      @(posedge clk);
      #1;
      chk("limpa_contagem", int'(contagem), 0);
      chk("limpa_out_valid", int'(out_valid), 0);
      @(negedge clk);
      limpa     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      send(5); send(5); send(5); send(5);
      #1 chk("limpa_blk", int'(out_data), MEDIA ? 5 : 20);
      chk("model_limpa", m_res, MEDIA ? 5 : 20);
      drain();

      // limpa during delivery drops the result even with out_ready high.
      send(9); send(9); send(9); send(9);
      @(negedge clk);
      chk("entrega_valid", int'(out_valid), 1);
      in_valid  = 1'b0;
      limpa     = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("limpa_entrega_valid", int'(out_valid), 0);
      chk("limpa_entrega_ready", int'(in_ready), 1);
      @(negedge clk);
      limpa     = 1'b0;
      out_ready = 1'b0;

      // Randomized traffic, checked every cycle by the model.
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         in_valid  = ($urandom_range(0, 2) != 0);
         case ($urandom_range(0, 7))
            0:       in_data = 9'd0;
            1:       in_data = 9'd511;
            default: in_data = 9'($urandom_range(0, 511));
         endcase
         out_ready = ($urandom_range(0, 3) != 0);
         limpa     = ($urandom_range(0, 39) == 0);
      end
      @(negedge clk);
      limpa = 1'b0;
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
